// File: rtl/fbmod_multi.sv
// Multi-channel feedback pulse counter.
// Each channel is synchronised, glitch-filtered and edge-detected; qualified edges are counted
// over a fixed window and the per-channel totals are published once per window together with
// a one-cycle valid strobe. Counts saturate instead of wrapping.
module fbmod_multi #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 125000000,
  parameter int unsigned FILT_LEN      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       inp_fb,
  input  logic [2*NCH-1:0]     edge_mode,
  output logic [NCH*CNT_W-1:0] edge_out,
  output logic [NCH-1:0]       sat_out,
  output logic                 win_valid
);

  // Window counter width; guarded so a degenerate parameter cannot give a zero-width vector.
  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------------------------
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;

  // Two-flop synchroniser per channel for the asynchronous feedback pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= inp_fb;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Glitch filter
  // ---------------------------------------------------------------------------------------------
  logic [NCH-1:0] filt;

  if (FILT_LEN == 0) begin : g_no_filt
    assign filt = sync2_q;
  end else begin : g_filt
    localparam int unsigned FC_W = $clog2(FILT_LEN + 1);
    // Counter value on the last disagreeing cycle before the filtered level flips.
    localparam logic [FC_W-1:0] FILT_TOP = FC_W'(FILT_LEN - 1);

    logic [NCH-1:0]  filt_q;
    logic [NCH-1:0]  filt_d;
    logic [FC_W-1:0] fcnt_q [NCH];
    logic [FC_W-1:0] fcnt_d [NCH];

    // The filtered level only follows the synced level after FILT_LEN consecutive cycles of
    // disagreement; any agreeing cycle restarts the count.
    always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < NCH; i++) begin
        fcnt_d[i] = '0;
        if (sync2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == FILT_TOP) begin
            filt_d[i] = sync2_q[i];
          end else begin
            fcnt_d[i] = fcnt_q[i] + 1'b1;
          end
        end
      end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= '0;
        for (int i = 0; i < NCH; i++) begin
          fcnt_q[i] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int i = 0; i < NCH; i++) begin
          fcnt_q[i] <= fcnt_d[i];
        end
      end
    end

    assign filt = filt_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------------------------
  logic [NCH-1:0] filt_prev_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] hit;

  // Delayed copy of the filtered level; cleared on reset so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_prev_q <= '0;
    end else begin
      filt_prev_q <= filt;
    end
  end

  assign rise = filt & ~filt_prev_q;
  assign fall = ~filt & filt_prev_q;

  // Qualify raw edges with the per-channel mode as sampled this cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      case (edge_mode[2*i +: 2])
        2'b00:   hit[i] = rise[i];
        2'b01:   hit[i] = fall[i];
        2'b10:   hit[i] = rise[i] | fall[i];
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Window timer
  // ---------------------------------------------------------------------------------------------
  logic [WIN_W-1:0] win_cnt_q;
  logic             win_end;

  assign win_end = en && (win_cnt_q == WIN_LAST);

  // Free-running window counter, held at zero while disabled so a fresh window starts on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else if (!en || win_end) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Live counters and publication
  // ---------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] live_q [NCH];
  logic [NCH-1:0]   live_sat_q;
  logic [CNT_W-1:0] bumped [NCH];
  logic [NCH-1:0]   ovf;

  // Count including this cycle's edge, saturating; ovf marks an edge that hit a full counter.
  // Publishing uses these values so an edge on the window-end cycle lands in the closing window.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ovf[i]    = hit[i] && (live_q[i] == CNT_MAX);
      bumped[i] = (hit[i] && !ovf[i]) ? live_q[i] + 1'b1 : live_q[i];
    end
  end

  // Live per-channel counts; cleared at window end and whenever measurement is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_sat_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
      end
    end else if (!en || win_end) begin
      live_sat_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
      end
    end else begin
      live_sat_q <= live_sat_q | ovf;
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= bumped[i];
      end
    end
  end

  // Published results and strobe; outputs hold between window ends, including while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_out  <= '0;
      sat_out   <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= win_end;
      if (win_end) begin
        sat_out <= live_sat_q | ovf;
        for (int i = 0; i < NCH; i++) begin
          edge_out[i*CNT_W +: CNT_W] <= bumped[i];
        end
      end
    end
  end

endmodule
